// File: rtl/rd_responder_if.sv
// Bus bundle for the rd/ws/ds read-strobe responder and its host write port.
// Carries the rpar parity line only when RD_RESP_PARITY_EN is defined.
interface rd_responder_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          rd;
   logic          ds;
   logic [AW-1:0] addr;
   logic          ws;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          err;
   logic          err_clr;
   logic          wr_en;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
`ifdef RD_RESP_PARITY_EN
   logic          rpar;
`endif

`ifdef RD_RESP_PARITY_EN
   modport master (output rd, ds, addr, err_clr, wr_en, waddr, wdata,
                   input  ws, rdata, rvalid, err, rpar);
   modport slave  (input  rd, ds, addr, err_clr, wr_en, waddr, wdata,
                   output ws, rdata, rvalid, err, rpar);
`else
   modport master (output rd, ds, addr, err_clr, wr_en, waddr, wdata,
                   input  ws, rdata, rvalid, err);
   modport slave  (input  rd, ds, addr, err_clr, wr_en, waddr, wdata,
                   output ws, rdata, rvalid, err);
`endif
endinterface

// File: rtl/rd_responder.sv
// Target-side responder for the rd/ws/ds read-strobe protocol with a host-loaded register array.
// Optional read-data parity output enabled by defining RD_RESP_PARITY_EN.
module rd_responder #(
   parameter int AW          = 4,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   rd_responder_if.slave bus
);
   localparam int         DEPTH    = 1 << AW;
   localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t        state_r;
   logic [7:0]    cnt_r;
   logic [AW-1:0] addr_r;
   logic          ws_r;
   logic [DW-1:0] rdata_r;
   logic          rvalid_r;
   logic          err_r;
   logic [DW-1:0] mem_r [DEPTH];

   logic [AW-1:0] rd_addr_s;
   logic [DW-1:0] rd_word_s;
   logic          err_set_s;

`ifdef RD_RESP_PARITY_EN
   logic          rpar_r;

   function automatic logic parity_of(input logic [DW-1:0] data);
      return ^data;
   endfunction
`endif

   // Host write port into the register array, active in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (bus.wr_en) begin
         mem_r[bus.waddr] <= bus.wdata;
      end
   end

   // Capture address and word: zero-wait reads use the live address, others the latched one.
   always_comb begin
      rd_addr_s = addr_r;
      if (state_r == IDLE) begin
         rd_addr_s = bus.addr;
      end else begin
         rd_addr_s = addr_r;
      end
      rd_word_s = mem_r[rd_addr_s];
   end

   // Protocol violations: done strobe outside DATA, or rd dropped during wait states.
   always_comb begin
      err_set_s = 1'b0;
      if (bus.ds && (state_r != DATA)) begin
         err_set_s = 1'b1;
      end else if ((state_r == BUSY) && !bus.rd) begin
         err_set_s = 1'b1;
      end else begin
         err_set_s = 1'b0;
      end
   end

   // Access FSM with registered ws/rdata/rvalid and the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         addr_r   <= '0;
         ws_r     <= 1'b0;
         rdata_r  <= '0;
         rvalid_r <= 1'b0;
         err_r    <= 1'b0;
`ifdef RD_RESP_PARITY_EN
         rpar_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               ws_r     <= 1'b0;
               rvalid_r <= 1'b0;
               if (bus.rd) begin
                  addr_r <= bus.addr;
                  if (NO_WAIT) begin
                     state_r  <= DATA;
                     rdata_r  <= rd_word_s;
                     rvalid_r <= 1'b1;
`ifdef RD_RESP_PARITY_EN
                     rpar_r   <= parity_of(rd_word_s);
`endif
                  end else begin
                     state_r <= BUSY;
                     ws_r    <= 1'b1;
                     cnt_r   <= CNT_LOAD;
                  end
               end
            end
            BUSY: begin
               if (!bus.rd) begin
                  state_r <= IDLE;
                  ws_r    <= 1'b0;
               end else if (cnt_r == 8'd0) begin
                  state_r  <= DATA;
                  ws_r     <= 1'b0;
                  rdata_r  <= rd_word_s;
                  rvalid_r <= 1'b1;
`ifdef RD_RESP_PARITY_EN
                  rpar_r   <= parity_of(rd_word_s);
`endif
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            DATA: begin
               if (bus.ds) begin
                  state_r  <= IDLE;
                  rvalid_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= IDLE;
               ws_r     <= 1'b0;
               rvalid_r <= 1'b0;
            end
         endcase

         // A fresh error outranks a simultaneous clear.
         if (err_set_s) begin
            err_r <= 1'b1;
         end else if (bus.err_clr) begin
            err_r <= 1'b0;
         end
      end
   end

   assign bus.ws     = ws_r;
   assign bus.rdata  = rdata_r;
   assign bus.rvalid = rvalid_r;
   assign bus.err    = err_r;
`ifdef RD_RESP_PARITY_EN
   assign bus.rpar   = rpar_r;
`endif

endmodule

// File: tb/tb_rd_responder.sv
// Directed scoreboard bench for rd_responder: three instances with WAIT_CYCLES of 2, 0 and 3.
module tb_rd_responder;
   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] sb_q [$];
   logic [7:0] model [3][16];

   logic       rd_v [3];
   logic       ds_v [3];
   logic       clr_v [3];
   logic       we_v [3];
   logic [3:0] addr_v [3];
   logic [3:0] waddr_v [3];
   logic [7:0] wdata_v [3];
   logic       ws_v [3];
   logic       rvalid_v [3];
   logic       err_v [3];
   logic       rpar_v [3];
   logic [7:0] rdata_v [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
      rd_responder_if #(.AW(4), .DW(8)) bus ();
      rd_responder #(.AW(4), .DW(8), .WAIT_CYCLES(W)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
      assign bus.rd      = rd_v[g];
      assign bus.ds      = ds_v[g];
      assign bus.addr    = addr_v[g];
      assign bus.err_clr = clr_v[g];
      assign bus.wr_en   = we_v[g];
      assign bus.waddr   = waddr_v[g];
      assign bus.wdata   = wdata_v[g];
      assign ws_v[g]     = bus.ws;
      assign rvalid_v[g] = bus.rvalid;
      assign err_v[g]    = bus.err;
      assign rdata_v[g]  = bus.rdata;
`ifdef RD_RESP_PARITY_EN
      assign rpar_v[g]   = bus.rpar;
`else
      assign rpar_v[g]   = 1'b0;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int d, input logic [3:0] a, input logic [7:0] data);
      @(negedge clk);
      we_v[d] = 1'b1; waddr_v[d] = a; wdata_v[d] = data;
      @(negedge clk);
      we_v[d] = 1'b0;
      model[d][a] = data;
   endtask

   // One compliant access: rd held until rvalid, then optional hold cycles and a ds pulse.
   task automatic access(input int d, input logic [3:0] a, input int w, input int hold, input bit send_ds);
      int         cyc;
      int         wsc;
      bit         got;
      logic [7:0] exp;
      cyc = 0; wsc = 0; got = 1'b0;
      @(negedge clk);
      rd_v[d] = 1'b1; addr_v[d] = a;
      sb_q.push_back(model[d][a]);
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) addr_v[d] = ~a;
         if (rvalid_v[d]) got = 1'b1;
         else if (ws_v[d]) wsc++;
      end
      rd_v[d] = 1'b0;
      exp = sb_q.pop_front();
      check("rvalid_timeout", 32'(got), 32'd1);
      if (got) begin
         check("ws_cycles", 32'(wsc), 32'(w));
         check("rvalid_latency", 32'(cyc), 32'(w + 1));
         check("rdata", 32'(rdata_v[d]), 32'(exp));
`ifdef RD_RESP_PARITY_EN
         check("rpar", 32'(rpar_v[d]), 32'(^exp));
`endif
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(rvalid_v[d]), 32'd1);
            check("rdata_hold", 32'(rdata_v[d]), 32'(exp));
         end
         if (send_ds) begin
            ds_v[d] = 1'b1;
            @(negedge clk);
            ds_v[d] = 1'b0;
            check("rvalid_after_ds", 32'(rvalid_v[d]), 32'd0);
            check("rdata_kept", 32'(rdata_v[d]), 32'(exp));
            check("ws_after_ds", 32'(ws_v[d]), 32'd0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         rd_v[d] = 1'b0; ds_v[d] = 1'b0; clr_v[d] = 1'b0; we_v[d] = 1'b0;
         addr_v[d] = 4'd0; waddr_v[d] = 4'd0; wdata_v[d] = 8'd0;
         for (int a = 0; a < 16; a++) model[d][a] = 8'd0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_ws", 32'(ws_v[d]), 32'd0);
         check("reset_rvalid", 32'(rvalid_v[d]), 32'd0);
         check("reset_rdata", 32'(rdata_v[d]), 32'd0);
         check("reset_err", 32'(err_v[d]), 32'd0);
      end
      rst_n = 1'b1;

      // Two wait states, ds one cycle after rvalid.
      host_write(0, 4'd3, 8'hA5);
      access(0, 4'd3, 2, 0, 1'b1);
      check("err_clean_w2", 32'(err_v[0]), 32'd0);

      // Zero wait states, data held until ds.
      host_write(1, 4'd0, 8'h3C);
      access(1, 4'd0, 0, 2, 1'b1);

      // rd dropped in the second wait-state cycle.
      @(negedge clk);
      rd_v[2] = 1'b1; addr_v[2] = 4'd7;
      @(negedge clk);
      check("abort_ws1", 32'(ws_v[2]), 32'd1);
      @(negedge clk);
      check("abort_ws2", 32'(ws_v[2]), 32'd1);
      rd_v[2] = 1'b0;
      @(negedge clk);
      check("abort_ws_low", 32'(ws_v[2]), 32'd0);
      check("abort_err", 32'(err_v[2]), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_rvalid", 32'(rvalid_v[2]), 32'd0);
         @(negedge clk);
      end
      clr_v[2] = 1'b1;
      @(negedge clk);
      clr_v[2] = 1'b0;
      check("err_cleared", 32'(err_v[2]), 32'd0);

      // Stray ds in IDLE, then ds racing err_clr.
      @(negedge clk);
      ds_v[2] = 1'b1;
      @(negedge clk);
      ds_v[2] = 1'b0;
      check("ds_idle_err", 32'(err_v[2]), 32'd1);
      check("ds_idle_rvalid", 32'(rvalid_v[2]), 32'd0);
      ds_v[2] = 1'b1; clr_v[2] = 1'b1;
      @(negedge clk);
      ds_v[2] = 1'b0; clr_v[2] = 1'b0;
      check("err_wins_clr", 32'(err_v[2]), 32'd1);
      clr_v[2] = 1'b1;
      @(negedge clk);
      clr_v[2] = 1'b0;
      check("err_cleared2", 32'(err_v[2]), 32'd0);
      host_write(2, 4'd4, 8'h5A);
      access(2, 4'd4, 3, 0, 1'b1);
      check("err_clean_w3", 32'(err_v[2]), 32'd0);

      // Write to the captured address in the capture cycle returns old data.
      host_write(1, 4'd5, 8'h11);
      @(negedge clk);
      rd_v[1] = 1'b1; addr_v[1] = 4'd5;
      we_v[1] = 1'b1; waddr_v[1] = 4'd5; wdata_v[1] = 8'h22;
      sb_q.push_back(model[1][5]);
      @(negedge clk);
      rd_v[1] = 1'b0; we_v[1] = 1'b0;
      model[1][5] = 8'h22;
      check("wr_race_rvalid", 32'(rvalid_v[1]), 32'd1);
      check("wr_race_rdata", 32'(rdata_v[1]), 32'(sb_q.pop_front()));
      ds_v[1] = 1'b1;
      @(negedge clk);
      ds_v[1] = 1'b0;
      access(1, 4'd5, 0, 0, 1'b1);
      check("err_clean_w0", 32'(err_v[1]), 32'd0);

      // Odd and even parity words.
      host_write(0, 4'd1, 8'h07);
      host_write(0, 4'd2, 8'h03);
      access(0, 4'd1, 2, 0, 1'b1);
      access(0, 4'd2, 2, 0, 1'b1);

      // Asynchronous reset while presenting data.
      access(0, 4'd1, 2, 0, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ws", 32'(ws_v[0]), 32'd0);
      check("arst_rvalid", 32'(rvalid_v[0]), 32'd0);
      check("arst_rdata", 32'(rdata_v[0]), 32'd0);
      check("arst_rpar", 32'(rpar_v[0]), 32'd0);
      for (int d = 0; d < 3; d++) begin
         for (int a = 0; a < 16; a++) model[d][a] = 8'd0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 4'd1, 2, 0, 1'b1);
      check("err_final", 32'(err_v[0]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
